// File: rtl/counter_pkg.sv
// counter_pkg: shared types and default sizes for the mod_counter block.
package counter_pkg;
    typedef enum logic [1:0] {CNT_WRAP, CNT_SAT, CNT_ONESHOT, CNT_RSVD} cnt_mode_t;
    typedef enum logic [0:0] {CNT_RUN, CNT_HALT} cnt_state_t;
    localparam int CNT_WIDTH      = 8;
    localparam int CNT_PRESCALE_W = 4;
endpackage

// File: rtl/mod_counter_if.sv
// mod_counter_if: control/status bundle of mod_counter; prescale exists only with COUNTER_PRESCALE_EN.
interface mod_counter_if #(parameter int WIDTH = 8, parameter int PRESCALE_W = 4) ();
    logic             en;
    logic             up_dn;
    logic [1:0]       mode;
    logic [WIDTH-1:0] max_val;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;
`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
    modport master (output en, up_dn, mode, max_val, clear, load, load_val, prescale,
                    input count, tc, done);
    modport slave  (input en, up_dn, mode, max_val, clear, load, load_val, prescale,
                    output count, tc, done);
`else
    modport master (output en, up_dn, mode, max_val, clear, load, load_val,
                    input count, tc, done);
    modport slave  (input en, up_dn, mode, max_val, clear, load, load_val,
                    output count, tc, done);
`endif
endinterface

// File: rtl/count_prescaler.sv
// count_prescaler: emits a tick once every div+1 enabled cycles; holds while en is low.
module count_prescaler #(parameter int W = 4) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] div,
    output logic         tick
);
    logic [W-1:0] cnt;
    // >= keeps the divider from running the full range if div is lowered mid-count
    assign tick = en && (cnt >= div);
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with load, clear and wrap/saturate/one-shot terminal modes.
// Define COUNTER_PRESCALE_EN to qualify steps with the count_prescaler tick.
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = CNT_WIDTH,
    parameter int PRESCALE_W = CNT_PRESCALE_W
) (
    input logic         clk,
    input logic         reset,
    mod_counter_if.slave bus
);
    logic [WIDTH-1:0] count, max_v, ld_v, up_nxt, dn_nxt;
    logic             tc, done, tick, step, term, wrap;
    cnt_state_t       state;
    cnt_mode_t        mode;
`ifdef COUNTER_PRESCALE_EN
    count_prescaler #(.W(PRESCALE_W)) u_pre (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear | bus.load),
        .en    (bus.en),
        .div   (bus.prescale),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif
    always_comb begin
        max_v  = bus.max_val;
        mode   = cnt_mode_t'(bus.mode);
        wrap   = (mode == CNT_WRAP) || (mode == CNT_RSVD);
        term   = bus.up_dn ? (count >= max_v) : (count == '0);
        step   = bus.en && tick && (state == CNT_RUN);
        ld_v   = (bus.load_val > max_v) ? max_v : bus.load_val;
        up_nxt = term ? (wrap ? '0 : count) : count + 1'b1;
        // a count left above a lowered max_val re-enters the range on a down step
        dn_nxt = term ? (wrap ? max_v : count) : ((count > max_v) ? max_v : count - 1'b1);
    end
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
            state <= CNT_RUN;
        end else if (bus.load) begin
            count <= ld_v;
            tc    <= 1'b0;
            done  <= 1'b0;
            state <= CNT_RUN;
        end else begin
            tc <= step && term;
            if (step) begin
                count <= bus.up_dn ? up_nxt : dn_nxt;
                if (term && mode == CNT_ONESHOT) begin
                    state <= CNT_HALT;
                    done  <= 1'b1;
                end
            end
        end
    end
    assign bus.count = count;
    assign bus.tc    = tc;
    assign bus.done  = done;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: randomized and directed checks of mod_counter against a spec-level reference model.
module tb_mod_counter;
    localparam int W  = 8;
    localparam int PW = 4;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    mod_counter_if #(.WIDTH(W), .PRESCALE_W(PW)) b ();
    mod_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (.clk(clk), .reset(reset), .bus(b));
    int checks = 0;
    int errors = 0;
    int m_count, m_tc, m_done, m_halt, m_div;

    // reference: the counter's rules applied to the inputs present at each rising edge
    task automatic model_update();
        int ps, mx, tick, step, is_term;
        ps = 0;
`ifdef COUNTER_PRESCALE_EN
        ps = int'(b.prescale);
`endif
        mx = int'(b.max_val);
        if (reset || b.clear) begin
            m_count = 0; m_tc = 0; m_done = 0; m_halt = 0; m_div = 0;
        end else if (b.load) begin
            m_count = (int'(b.load_val) > mx) ? mx : int'(b.load_val);
            m_tc = 0; m_done = 0; m_halt = 0; m_div = 0;
        end else begin
            tick = 0;
            if (b.en) begin
                if (m_div >= ps) begin tick = 1; m_div = 0; end
                else m_div = m_div + 1;
            end
            step = (b.en && tick && !m_halt) ? 1 : 0;
            m_tc = 0;
            if (step) begin
                is_term = b.up_dn ? (m_count >= mx) : (m_count == 0);
                if (is_term) begin
                    m_tc = 1;
                    if (b.mode == 2'd2) begin m_halt = 1; m_done = 1; end
                    else if (b.mode != 2'd1) m_count = b.up_dn ? 0 : mx;
                end else if (b.up_dn) m_count = m_count + 1;
                else m_count = (m_count > mx) ? mx : m_count - 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        b.en = 0; b.up_dn = 1; b.mode = 2'd0; b.max_val = 8'd5;
        b.clear = 0; b.load = 0; b.load_val = 0;
`ifdef COUNTER_PRESCALE_EN
        b.prescale = 0;
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        cycle(); cycle();
        checks++; if (b.count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", b.count); end
        checks++; if (b.tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b want=0", b.tc); end
        checks++; if (b.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", b.done); end
        reset = 0;
    endtask

    task automatic test_wrap();
        b.mode = 2'd0; b.up_dn = 1; b.max_val = 8'd5; b.clear = 1;
        cycle();
        b.clear = 0; b.en = 1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            checks++;
            if (b.count !== W'(m_count) || b.tc !== m_tc[0] || int'(b.count) != (i % 6)) begin
                errors++;
                $display("FAIL wrap_step%0d count=%0d tc=%b want count=%0d tc=%0d", i, b.count, b.tc, i % 6, m_tc);
            end
            if (i == 6) begin
                checks++; if (b.tc !== 1'b1) begin errors++; $display("FAIL wrap_tc got=%b want=1", b.tc); end
            end
            if (i == 7) begin
                checks++; if (b.tc !== 1'b0) begin errors++; $display("FAIL wrap_tc_pulse got=%b want=0", b.tc); end
            end
        end
        b.en = 0;
    endtask

    task automatic test_sat();
        int exp_seq[5] = '{2, 1, 0, 0, 0};
        b.mode = 2'd1; b.up_dn = 0; b.max_val = 8'd9; b.load = 1; b.load_val = 8'd2;
        cycle();
        b.load = 0; b.en = 1;
        checks++; if (b.count !== 8'd2) begin errors++; $display("FAIL sat_load got=%0d want=2", b.count); end
        for (int i = 1; i < 5; i++) begin
            cycle();
            checks++;
            if (b.count !== W'(exp_seq[i]) || b.tc !== m_tc[0] || b.tc !== (i >= 3) || b.done !== 1'b0) begin
                errors++;
                $display("FAIL sat_step%0d count=%0d tc=%b done=%b want count=%0d tc=%0d done=0",
                         i, b.count, b.tc, b.done, exp_seq[i], i >= 3);
            end
        end
        b.en = 0;
    endtask

    task automatic test_oneshot();
        b.mode = 2'd2; b.up_dn = 1; b.max_val = 8'd3; b.clear = 1;
        cycle();
        b.clear = 0; b.en = 1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            checks++;
            if (b.count !== W'(m_count) || b.done !== m_done[0] || b.tc !== m_tc[0]) begin
                errors++;
                $display("FAIL oneshot_step%0d count=%0d done=%b tc=%b want %0d/%0d/%0d",
                         i, b.count, b.done, b.tc, m_count, m_done, m_tc);
            end
        end
        checks++;
        if (b.count !== 8'd3 || b.done !== 1'b1) begin
            errors++; $display("FAIL oneshot_hold count=%0d done=%b want 3/1", b.count, b.done);
        end
        b.clear = 1;
        cycle();
        b.clear = 0;
        checks++;
        if (b.count !== 8'd0 || b.done !== 1'b0) begin
            errors++; $display("FAIL oneshot_clear count=%0d done=%b want 0/0", b.count, b.done);
        end
        b.en = 0;
    endtask

    task automatic test_load_clamp();
        b.mode = 2'd0; b.max_val = 8'd10; b.load = 1; b.load_val = 8'd200;
        cycle();
        checks++; if (b.count !== 8'd10) begin errors++; $display("FAIL load_clamp got=%0d want=10", b.count); end
        b.clear = 1;
        cycle();
        b.clear = 0; b.load = 0;
        checks++; if (b.count !== 8'd0) begin errors++; $display("FAIL clear_over_load got=%0d want=0", b.count); end
    endtask

    task automatic test_reset_midrun();
        b.mode = 2'd0; b.up_dn = 1; b.max_val = 8'd20; b.load = 1; b.load_val = 8'd6;
        cycle();
        b.load = 0; b.en = 1;
        cycle();
        checks++; if (b.count !== 8'd7) begin errors++; $display("FAIL midrun_pre got=%0d want=7", b.count); end
        reset = 1; b.load = 1; b.load_val = 8'd15;
        cycle();
        reset = 0; b.load = 0; b.en = 0;
        checks++;
        if (b.count !== 8'd0 || b.tc !== 1'b0 || b.done !== 1'b0) begin
            errors++; $display("FAIL midrun_reset count=%0d tc=%b done=%b want 0/0/0", b.count, b.tc, b.done);
        end
    endtask

`ifdef COUNTER_PRESCALE_EN
    task automatic test_prescale();
        int start;
        b.mode = 2'd0; b.up_dn = 1; b.max_val = 8'd100; b.prescale = 4'd2; b.clear = 1;
        cycle();
        b.clear = 0; b.en = 1;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            checks++;
            if (b.count !== W'(i / 3)) begin
                errors++; $display("FAIL prescale_cyc%0d count=%0d want=%0d", i, b.count, i / 3);
            end
        end
        b.en = 1;
        cycle();
        b.en = 0;
        start = int'(b.count);
        repeat (5) cycle();
        b.en = 1;
        cycle(); cycle();
        checks++;
        if (b.count !== W'(start + 1) || b.count !== W'(m_count)) begin
            errors++; $display("FAIL prescale_hold count=%0d want=%0d", b.count, start + 1);
        end
        b.en = 0; b.prescale = 0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(199) == 0);
            b.clear    = ($urandom_range(59) == 0);
            b.load     = ($urandom_range(29) == 0);
            b.load_val = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(20));
            b.en       = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) b.up_dn = 1'($urandom);
            if ($urandom_range(31) == 0) b.mode = 2'($urandom);
            if ($urandom_range(40) == 0) b.max_val = ($urandom_range(7) == 0) ? 8'($urandom) : 8'($urandom_range(12));
`ifdef COUNTER_PRESCALE_EN
            if ($urandom_range(50) == 0) b.prescale = 4'($urandom_range(3));
`endif
            cycle();
            checks++;
            if (b.count !== W'(m_count) || b.tc !== m_tc[0] || b.done !== m_done[0]) begin
                errors++;
                $display("FAIL random_cyc%0d count=%0d tc=%b done=%b want %0d/%0d/%0d",
                         i, b.count, b.tc, b.done, m_count, m_tc, m_done);
            end
        end
        reset = 0;
    endtask

    initial begin
        m_count = 0; m_tc = 0; m_done = 0; m_halt = 0; m_div = 0;
        test_reset();
        test_wrap();
        test_sat();
        test_oneshot();
        test_load_clamp();
        test_reset_midrun();
`ifdef COUNTER_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
